// File: rtl/c2f_seq.sv
`default_nettype none
// ============================================================================
//  Module   : c2f_seq
//  Purpose  : Time-multiplexed C2f sequencer. Buffers cv1 maps, runs n
//             bottleneck passes through a shared external engine, then streams
//             the (2+n) segment concatenation pixel-major.
//  Revision : 1.0  initial release
// ============================================================================
module c2f_seq #(
    parameter int MID_CH = 4,
    parameter int IN_H   = 4,
    parameter int IN_W   = 4,
    parameter int WIDTH  = 16,
    parameter int N_MAX  = 4,
    localparam int NW    = $clog2(N_MAX + 1),
    localparam int DW    = MID_CH * WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NW-1:0]     n_cfg,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   in_data,
    output logic              eng_out_valid,
    input  logic              eng_out_ready,
    output logic [DW-1:0]     eng_out_data,
    output logic              eng_out_last,
    input  logic              eng_in_valid,
    output logic              eng_in_ready,
    input  logic [DW-1:0]     eng_in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [NW:0]       out_seg,
    output logic              out_last
);

    localparam int PIX  = IN_H * IN_W;
    localparam int NSEG = N_MAX + 2;
    localparam int AW   = $clog2(NSEG * PIX);
    localparam int CW   = $clog2(PIX + 1);

    localparam logic [CW-1:0] C_PIX      = CW'(PIX);
    localparam logic [CW-1:0] C_PIX_LAST = CW'(PIX - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [NW-1:0] C_N_MAX    = NW'(N_MAX);
    localparam logic [NW-1:0] C_K_ONE    = NW'(1);
    localparam logic [NW:0]   C_SEG_ONE  = (NW + 1)'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_BN   = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]     r_state;
    logic [2:0]     w_state_nxt;
    logic [NW-1:0]  r_n_lat;
    logic [NW-1:0]  r_k;
    logic [CW-1:0]  r_ld_cnt;
    logic [CW-1:0]  r_iss;
    logic [CW-1:0]  r_col;
    logic [CW-1:0]  r_op;
    logic [NW:0]    r_os;
    logic           r_out_all;
    logic [DW-1:0]  r_mem [NSEG*PIX];

    logic           w_in_fire;
    logic           w_eo_fire;
    logic           w_ei_fire;
    logic           w_out_fire;
    logic           w_ld_end;
    logic           w_pass_end;
    logic           w_last_pass;
    logic           w_eo_load;
    logic           w_out_load;
    logic [NW:0]    w_seg_top;

    function automatic logic [AW-1:0] f_addr(input int seg, input logic [CW-1:0] pix);
        return AW'(seg * PIX + int'(pix));
    endfunction

    assign w_in_fire   = in_valid && in_ready;
    assign w_eo_fire   = eng_out_valid && eng_out_ready;
    assign w_ei_fire   = eng_in_valid && eng_in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_ld_end    = w_in_fire && (r_ld_cnt == C_PIX_LAST);
    // A pass closes only once the final issued beat has actually been taken.
    assign w_pass_end  = (r_state == S_BN) && (r_iss == C_PIX) && !eng_out_valid && (r_col == C_PIX);
    assign w_last_pass = (r_k + C_K_ONE) == r_n_lat;
    assign w_seg_top   = {1'b0, r_n_lat} + C_SEG_ONE;
    assign w_eo_load   = (r_state == S_BN) && (r_iss != C_PIX) && (!eng_out_valid || eng_out_ready);
    assign w_out_load  = (r_state == S_OUT) && !r_out_all && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_LOAD;
            S_LOAD: if (w_ld_end) w_state_nxt = (r_n_lat != '0) ? S_BN : S_OUT;
            S_BN:   if (w_pass_end && w_last_pass) w_state_nxt = S_OUT;
            S_OUT:  if (w_out_fire && out_last) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state == S_LOAD) || (r_state == S_BN) || (r_state == S_OUT);
        done         = (r_state == S_DONE);
        in_ready     = (r_state == S_LOAD);
        eng_in_ready = (r_state == S_BN) && (r_col != C_PIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_lat       <= '0;
            r_k           <= '0;
            r_ld_cnt      <= '0;
            r_iss         <= '0;
            r_col         <= '0;
            r_op          <= '0;
            r_os          <= '0;
            r_out_all     <= 1'b0;
            eng_out_valid <= 1'b0;
            eng_out_data  <= '0;
            eng_out_last  <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_seg       <= '0;
            out_last      <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_k       <= '0;
                r_ld_cnt  <= '0;
                r_iss     <= '0;
                r_col     <= '0;
                r_op      <= '0;
                r_os      <= '0;
                r_out_all <= 1'b0;
                if (start) r_n_lat <= (n_cfg > C_N_MAX) ? C_N_MAX : n_cfg;
            end

            if (w_in_fire) r_ld_cnt <= r_ld_cnt + C_CNT_ONE;

            if (w_pass_end) begin
                r_iss <= '0;
                r_col <= '0;
                r_k   <= r_k + C_K_ONE;
            end else begin
                if (w_eo_load) r_iss <= r_iss + C_CNT_ONE;
                if (w_ei_fire) r_col <= r_col + C_CNT_ONE;
            end

            // Pass k feeds segment k+1 to the engine.
            if (w_eo_load) begin
                eng_out_valid <= 1'b1;
                eng_out_data  <= r_mem[f_addr(int'(r_k) + 1, r_iss)];
                eng_out_last  <= (r_iss == C_PIX_LAST);
            end else if (w_eo_fire) begin
                eng_out_valid <= 1'b0;
                eng_out_last  <= 1'b0;
            end

            if (w_out_load) begin
                out_valid <= 1'b1;
                out_data  <= r_mem[f_addr(int'(r_os), r_op)];
                out_seg   <= r_os;
                out_last  <= (r_op == C_PIX_LAST) && (r_os == w_seg_top);
                if (r_os == w_seg_top) begin
                    r_os <= '0;
                    r_op <= r_op + C_CNT_ONE;
                    if (r_op == C_PIX_LAST) r_out_all <= 1'b1;
                end else begin
                    r_os <= r_os + C_SEG_ONE;
                end
            end else if (w_out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Segment buffer is deliberately not reset; every run rewrites what it reads.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_mem[f_addr(0, r_ld_cnt)] <= in_data[DW-1:0];
            r_mem[f_addr(1, r_ld_cnt)] <= in_data[2*DW-1:DW];
        end
        if (w_ei_fire) begin
            r_mem[f_addr(int'(r_k) + 2, r_col)] <= eng_in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_c2f_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c2f_seq
//  Purpose  : Self-checking bench for c2f_seq against a concatenation model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c2f_seq;

    localparam int MID_CH = 4;
    localparam int IN_H   = 4;
    localparam int IN_W   = 4;
    localparam int WIDTH  = 16;
    localparam int N_MAX  = 4;
    localparam int NW     = $clog2(N_MAX + 1);
    localparam int DW     = MID_CH * WIDTH;
    localparam int PIX    = IN_H * IN_W;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [NW-1:0]   n_cfg;
    logic            busy;
    logic            done;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in_data;
    logic            eng_out_valid;
    logic            eng_out_ready;
    logic [DW-1:0]   eng_out_data;
    logic            eng_out_last;
    logic            eng_in_valid;
    logic            eng_in_ready;
    logic [DW-1:0]   eng_in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [NW:0]     out_seg;
    logic            out_last;

    c2f_seq #(
        .MID_CH (MID_CH),
        .IN_H   (IN_H),
        .IN_W   (IN_W),
        .WIDTH  (WIDTH),
        .N_MAX  (N_MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .n_cfg         (n_cfg),
        .busy          (busy),
        .done          (done),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .eng_out_valid (eng_out_valid),
        .eng_out_ready (eng_out_ready),
        .eng_out_data  (eng_out_data),
        .eng_out_last  (eng_out_last),
        .eng_in_valid  (eng_in_valid),
        .eng_in_ready  (eng_in_ready),
        .eng_in_data   (eng_in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_seg       (out_seg),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference state: source maps, expected concat stream, engine result queue.
    logic [DW-1:0] x1 [PIX];
    logic [DW-1:0] x2 [PIX];
    logic [DW-1:0] exp_data [$];
    int            exp_seg  [$];
    bit            exp_last [$];
    logic [DW-1:0] res_q    [$];
    int            res_t    [$];
    int  cyc, in_idx, iss, col, out_cnt, done_cnt, hold;
    bit  rnd, oracle, poke;

    function automatic logic [DW-1:0] lanes_add(input logic [DW-1:0] v, input int inc);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < MID_CH; l++) r[l*WIDTH +: WIDTH] = v[l*WIDTH +: WIDTH] + WIDTH'(inc);
        return r;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      64'(busy), 64'(0));
        check({tag, "_done"},      64'(done), 64'(0));
        check({tag, "_in_ready"},  64'(in_ready), 64'(0));
        check({tag, "_eo_valid"},  64'(eng_out_valid), 64'(0));
        check({tag, "_eo_last"},   64'(eng_out_last), 64'(0));
        check({tag, "_eo_data"},   64'(eng_out_data), 64'(0));
        check({tag, "_ei_ready"},  64'(eng_in_ready), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_seg"},   64'(out_seg), 64'(0));
        check({tag, "_out_last"},  64'(out_last), 64'(0));
        check({tag, "_out_data"},  64'(out_data), 64'(0));
    endtask

    // One cycle: drive inputs at the falling edge, then record what the next rising edge transfers.
    task automatic tick();
        logic [DW-1:0] ed;
        int            es;
        bit            el;
        @(negedge clk);
        cyc++;
        in_valid = (in_idx < PIX);
        in_data  = '0;
        if (in_idx < PIX) in_data = {x2[in_idx], x1[in_idx]};
        if (poke) begin
            start = (in_idx == 5);
            if (start) n_cfg = NW'(3);
        end
        out_ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        eng_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hold > 0 && iss == PIX - 1) eng_out_ready = 1'b0;
        eng_in_valid = 1'b0;
        eng_in_data  = '0;
        if (res_q.size() > 0 && res_t[0] <= cyc && (!rnd || $urandom_range(0, 1) == 1)) begin
            eng_in_valid = 1'b1;
            eng_in_data  = res_q[0];
        end

        if (in_valid && in_ready) in_idx++;
        if (eng_out_valid && eng_out_ready) begin
            check("eng_last", 64'(eng_out_last), 64'((iss % PIX) == PIX - 1));
            check("eng_src", 64'(eng_out_data), 64'(lanes_add(x2[iss % PIX], iss / PIX)));
            if (!oracle) begin
                res_q.push_back(lanes_add(eng_out_data, 1));
                res_t.push_back(cyc + 3);
            end
            iss++;
        end
        if (hold > 0 && col == PIX && eng_in_valid) begin
            check("eng_in_stall", 64'(eng_in_ready), 64'(0));
            hold--;
        end
        if (eng_in_valid && eng_in_ready) begin
            void'(res_q.pop_front());
            void'(res_t.pop_front());
            col++;
        end
        if (out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
                check("extra_beat", 64'(1), 64'(0));
            end else begin
                ed = exp_data.pop_front();
                es = exp_seg.pop_front();
                el = exp_last.pop_front();
                check("out_data", 64'(out_data), 64'(ed));
                check("out_seg",  64'(out_seg), 64'(es));
                check("out_last", 64'(out_last), 64'(el));
            end
            out_cnt++;
        end
        if (done) begin
            done_cnt++;
            check("done_busy", 64'(busy), 64'(0));
        end
    endtask

    task automatic run(input int n, input bit r, input bit pat, input bit orc, input bit pk, input int abort_at);
        int nl;
        int t;
        nl = (n > N_MAX) ? N_MAX : n;
        rnd = r; oracle = orc; poke = pk; hold = orc ? 4 : 0;
        in_idx = 0; iss = 0; col = 0; out_cnt = 0; done_cnt = 0;
        res_q.delete(); res_t.delete();
        exp_data.delete(); exp_seg.delete(); exp_last.delete();
        for (int p = 0; p < PIX; p++) begin
            x1[p] = pat ? {MID_CH{WIDTH'(p)}}       : {$urandom, $urandom};
            x2[p] = pat ? {MID_CH{WIDTH'(100 + p)}} : {$urandom, $urandom};
        end
        // Segment 0 is x1, segment s>=1 is x2 after s-1 "+1" engine passes.
        for (int p = 0; p < PIX; p++) begin
            for (int s = 0; s <= nl + 1; s++) begin
                exp_data.push_back(s == 0 ? x1[p] : lanes_add(x2[p], s - 1));
                exp_seg.push_back(s);
                exp_last.push_back(p == PIX - 1 && s == nl + 1);
            end
        end
        if (orc) begin
            for (int k = 0; k < nl; k++)
                for (int j = 0; j < PIX; j++) begin
                    res_q.push_back(lanes_add(x2[j], k + 1));
                    res_t.push_back(0);
                end
        end
        start = 1'b1;
        n_cfg = NW'(n);
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            if (abort_at >= 0 && iss == abort_at) return;
            tick();
            t++;
        end
        if (t >= 3000) check("timeout", 64'(1), 64'(0));
        repeat (3) tick();
        check("done_count", 64'(done_cnt), 64'(1));
        check("beat_count", 64'(out_cnt), 64'((nl + 2) * PIX));
        check("beats_left", 64'(exp_data.size()), 64'(0));
        check("issue_count", 64'(iss), 64'(nl * PIX));
        poke = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; n_cfg = '0;
        in_valid = 1'b0; in_data = '0;
        eng_out_ready = 1'b0; eng_in_valid = 1'b0; eng_in_data = '0; out_ready = 1'b0;
        cyc = 0; in_idx = PIX; iss = 0; col = 0; out_cnt = 0; done_cnt = 0; hold = 0;
        rnd = 1'b0; oracle = 1'b0; poke = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run(2, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        run(2, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        run(7, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Abort in pass 1 while pixel 7 is being offered to the engine.
        run(2, 1'b0, 1'b0, 1'b0, 1'b0, PIX + 7);
        check("pre_abort_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        in_valid = 1'b0; eng_in_valid = 1'b0;
        res_q.delete(); res_t.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(1, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Early engine results, a held last issue, and a start poke during LOAD.
        run(2, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        run(3, 1'b1, 1'b0, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
